// File: rtl/data_memory_mmio.sv
// Data memory with byte-lane RAM and a 256-byte MMIO page on the CPU load/store port.
// Loads return one cycle after the request on read_data with a one-cycle read_valid strobe.
// The MMIO page holds ID constants, synchronised switches, an LED register and a 64-bit
// cycle counter whose high word is captured when the low word is read.
module data_memory_mmio #(
    parameter int          MEM_BYTES = 4096,
    parameter logic [31:0] RAM_BASE  = 32'h2000_0000,
    parameter logic [31:0] MMIO_BASE = 32'h0010_0000,
    parameter int          SW_WIDTH  = 16,
    parameter int          LED_WIDTH = 16,
    parameter logic [31:0] ID0       = 32'h1719_2051,
    parameter logic [31:0] ID1       = 32'h1672_6992,
    parameter logic [31:0] ID2       = 32'h1672_6992
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_enable,
    input  logic                 write_enable,
    input  logic [3:0]           byte_sel,
    input  logic [31:0]          memory_addr,
    input  logic [31:0]          write_data,
    input  logic [SW_WIDTH-1:0]  user_switch,
    output logic [31:0]          read_data,
    output logic                 read_valid,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 access_err
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int WORDS = MEM_BYTES / 4;
    localparam int IW    = AW - 2;

    // MMIO word offsets (memory_addr[7:2])
    localparam logic [5:0] OFF_ID0    = 6'h00;
    localparam logic [5:0] OFF_ID1    = 6'h01;
    localparam logic [5:0] OFF_ID2    = 6'h02;
    localparam logic [5:0] OFF_SW     = 6'h04;
    localparam logic [5:0] OFF_LED    = 6'h05;
    localparam logic [5:0] OFF_CNT_LO = 6'h06;
    localparam logic [5:0] OFF_CNT_HI = 6'h07;

    // One array per byte lane; kept free of reset so it maps onto block RAM.
    logic [7:0] ram [4][WORDS];

    logic [IW-1:0]        ram_idx;
    logic                 ram_hit;
    logic                 mmio_hit;
    logic                 off_ok;
    logic [5:0]           mmio_word;
    logic                 unmapped;
    logic [31:0]          ram_rdata;
    logic [31:0]          mmio_rdata;
    logic [31:0]          led_next;
    logic [SW_WIDTH-1:0]  sw_meta;
    logic [SW_WIDTH-1:0]  sw_sync;
    logic [LED_WIDTH-1:0] led_q;
    logic [63:0]          cycle_cnt;
    logic [31:0]          shadow_hi;
    logic                 unused_addr_bits;

    // Byte offset within the word is irrelevant for word accesses.
    assign unused_addr_bits = &{1'b0, memory_addr[1:0]};

    assign leds = led_q;

    // Address decode, MMIO read mux and byte-merged LED write value
    always_comb begin
        ram_hit   = (memory_addr[31:AW] == RAM_BASE[31:AW]);
        mmio_hit  = (memory_addr[31:8] == MMIO_BASE[31:8]);
        ram_idx   = memory_addr[AW-1:2];
        mmio_word = memory_addr[7:2];
        ram_rdata = {ram[3][ram_idx], ram[2][ram_idx], ram[1][ram_idx], ram[0][ram_idx]};

        off_ok     = 1'b1;
        mmio_rdata = 32'h0;
        case (mmio_word)
            OFF_ID0:    mmio_rdata = ID0;
            OFF_ID1:    mmio_rdata = ID1;
            OFF_ID2:    mmio_rdata = ID2;
            OFF_SW:     mmio_rdata = 32'(sw_sync);
            OFF_LED:    mmio_rdata = 32'(led_q);
            OFF_CNT_LO: mmio_rdata = cycle_cnt[31:0];
            OFF_CNT_HI: mmio_rdata = shadow_hi;
            default: begin
                off_ok     = 1'b0;
                mmio_rdata = 32'h0;
            end
        endcase

        unmapped = !ram_hit && !(mmio_hit && off_ok);

        led_next = 32'(led_q);
        for (int i = 0; i < 4; i++) begin
            if (byte_sel[i]) begin
                led_next[8*i +: 8] = write_data[8*i +: 8];
            end
        end
    end

    // RAM lane writes; the read happens in the same edge from the old contents (read-first)
    always_ff @(posedge clk) begin
        if (!reset && write_enable && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_sel[i]) begin
                    ram[i][ram_idx] <= write_data[8*i +: 8];
                end
            end
        end
    end

    // Two-flop synchroniser for the asynchronous switch inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= user_switch;
            sw_sync <= sw_meta;
        end
    end

    // Free-running 64-bit cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= 64'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
        end
    end

    // Load result, strobe, error pulse, LED register and counter high-word shadow
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data  <= 32'h0;
            read_valid <= 1'b0;
            access_err <= 1'b0;
            led_q      <= '0;
            shadow_hi  <= 32'h0;
        end else begin
            read_valid <= read_enable;
            access_err <= (read_enable || write_enable) && unmapped;
            if (read_enable) begin
                if (ram_hit) begin
                    read_data <= ram_rdata;
                end else if (mmio_hit && off_ok) begin
                    read_data <= mmio_rdata;
                end else begin
                    read_data <= 32'h0;
                end
                // Capturing the high word here keeps a lo-then-hi read pair coherent.
                if (!ram_hit && mmio_hit && mmio_word == OFF_CNT_LO) begin
                    shadow_hi <= cycle_cnt[63:32];
                end
            end
            if (write_enable && !ram_hit && mmio_hit && mmio_word == OFF_LED) begin
                led_q <= led_next[LED_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Scoreboard bench for data_memory_mmio: the driver updates a behavioural model and queues
// the expected per-cycle response; a monitor compares whatever the DUT presents.
module tb_data_memory_mmio;

    localparam logic [31:0] RAM_B  = 32'h2000_0000;
    localparam logic [31:0] MMIO_B = 32'h0010_0000;
    localparam logic [31:0] ID0_V  = 32'h1719_2051;
    localparam logic [31:0] ID1_V  = 32'h1672_6992;
    localparam logic [31:0] ID2_V  = 32'h1672_6992;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_enable;
    logic        write_enable;
    logic [3:0]  byte_sel;
    logic [31:0] memory_addr;
    logic [31:0] write_data;
    logic [15:0] user_switch;
    logic [31:0] read_data;
    logic        read_valid;
    logic [15:0] leds;
    logic        access_err;

    always #5 clk = ~clk;

    data_memory_mmio dut (
        .clk          (clk),
        .reset        (reset),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .byte_sel     (byte_sel),
        .memory_addr  (memory_addr),
        .write_data   (write_data),
        .user_switch  (user_switch),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .leds         (leds),
        .access_err   (access_err)
    );

    typedef struct packed {
        logic        rv;
        logic        err;
        logic [15:0] leds;
    } cyc_t;

    cyc_t        cyc_q[$];
    logic [31:0] rd_q[$];
    int          total = 0;
    int          bad = 0;
    bit          mon_on = 0;

    // Reference model state
    logic [31:0] mem_m [1024];
    logic [15:0] leds_m;
    logic [63:0] cnt_m;
    logic [31:0] shadow_m;
    logic [15:0] sw_h1, sw_h2;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one expected cycle record per driven cycle, read data popped on read_valid
    cyc_t mon_c;
    always @(posedge clk) begin
        #1;
        if (mon_on && cyc_q.size() > 0) begin
            mon_c = cyc_q.pop_front();
            check("read_valid", {31'h0, read_valid}, {31'h0, mon_c.rv});
            check("access_err", {31'h0, access_err}, {31'h0, mon_c.err});
            check("leds", {16'h0, leds}, {16'h0, mon_c.leds});
        end
        if (mon_on && read_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL read_data: unexpected read_valid, data %h", read_data);
            end else begin
                check("read_data", read_data, rd_q.pop_front());
            end
        end
    end

    // Drive one cycle of stimulus and advance the model across the following edge
    task automatic step(input logic rst, input logic re, input logic we, input logic [3:0] bs,
                        input logic [31:0] a, input logic [31:0] wd, input logic [15:0] sw);
        logic        is_ram, is_mmio, off_ok;
        logic [5:0]  w;
        logic [31:0] val, l32;
        cyc_t        c;
        @(negedge clk);
        reset        = rst;
        read_enable  = re;
        write_enable = we;
        byte_sel     = bs;
        memory_addr  = a;
        write_data   = wd;
        user_switch  = sw;

        is_ram  = (a[31:12] == RAM_B[31:12]);
        is_mmio = (a[31:8] == MMIO_B[31:8]);
        w       = a[7:2];
        off_ok  = (w inside {6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7});

        if (rst) begin
            leds_m   = 16'h0;
            shadow_m = 32'h0;
            cnt_m    = 64'h0;
            sw_h1    = 16'h0;
            sw_h2    = 16'h0;
            c.rv = 1'b0;
            c.err = 1'b0;
            c.leds = 16'h0;
            cyc_q.push_back(c);
        end else begin
            if (re) begin
                val = 32'h0;
                if (is_ram) begin
                    val = mem_m[a[11:2]];
                end else if (is_mmio) begin
                    case (w)
                        6'd0: val = ID0_V;
                        6'd1: val = ID1_V;
                        6'd2: val = ID2_V;
                        6'd4: val = {16'h0, sw_h2};
                        6'd5: val = {16'h0, leds_m};
                        6'd6: val = cnt_m[31:0];
                        6'd7: val = shadow_m;
                        default: val = 32'h0;
                    endcase
                    if (w == 6'd6) shadow_m = cnt_m[63:32];
                end
                rd_q.push_back(val);
            end
            if (we) begin
                if (is_ram) begin
                    for (int b = 0; b < 4; b++)
                        if (bs[b]) mem_m[a[11:2]][8*b +: 8] = wd[8*b +: 8];
                end else if (is_mmio && w == 6'd5) begin
                    l32 = {16'h0, leds_m};
                    for (int b = 0; b < 4; b++)
                        if (bs[b]) l32[8*b +: 8] = wd[8*b +: 8];
                    leds_m = l32[15:0];
                end
            end
            c.rv   = re;
            c.err  = (re || we) && !is_ram && !(is_mmio && off_ok);
            c.leds = leds_m;
            cyc_q.push_back(c);
            cnt_m = cnt_m + 64'd1;
            sw_h2 = sw_h1;
            sw_h1 = sw;
        end
        mon_on = 1;
    endtask

    task automatic idle(input int n, input logic [15:0] sw);
        for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 32'h0, 32'h0, sw);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        case ($urandom_range(0, 2))
            0: r = RAM_B | ($urandom & 32'h0000_0FFF);
            1: r = ($urandom_range(0, 3) == 0) ? (MMIO_B | 32'($urandom_range(0, 255)))
                                               : (MMIO_B | 32'($urandom_range(0, 7) * 4));
            default: r = $urandom;
        endcase
        return r;
    endfunction

    logic [15:0] sw_cur;

    initial begin
        reset = 1; read_enable = 0; write_enable = 0; byte_sel = 0;
        memory_addr = 0; write_data = 0; user_switch = 0;
        sw_cur = 16'h0;

        // Reset with pending requests: no strobe, LEDs stay cleared
        for (int i = 0; i < 3; i++) step(1, 1, 1, 4'hF, MMIO_B + 32'h14, 32'hFFFF_FFFF, sw_cur);

        // Give every RAM word a known value
        for (int i = 0; i < 1024; i++) step(0, 0, 1, 4'hF, RAM_B + 32'(i * 4), $urandom, sw_cur);

        // Byte-lane writes
        step(0, 0, 1, 4'hF, RAM_B + 32'h10, 32'hDEAD_BEEF, sw_cur);
        step(0, 1, 0, 4'h0, RAM_B + 32'h10, 32'h0, sw_cur);
        step(0, 0, 1, 4'b0001, RAM_B + 32'h10, 32'h0000_0055, sw_cur);
        step(0, 1, 0, 4'h0, RAM_B + 32'h10, 32'h0, sw_cur);
        step(0, 0, 1, 4'b1000, RAM_B + 32'h10, 32'h1122_3344, sw_cur);
        step(0, 1, 0, 4'h0, RAM_B + 32'h11, 32'h0, sw_cur);

        // Read-first on a same-cycle read/write
        step(0, 0, 1, 4'hF, RAM_B + 32'h20, 32'h0, sw_cur);
        step(0, 1, 1, 4'hF, RAM_B + 32'h20, 32'hCAFE_0000, sw_cur);
        step(0, 1, 0, 4'h0, RAM_B + 32'h20, 32'h0, sw_cur);

        // Top word of RAM and the first address past it
        step(0, 0, 1, 4'hF, RAM_B + 32'hFFC, 32'h5A5A_0FFC, sw_cur);
        step(0, 1, 0, 4'h0, RAM_B + 32'hFFC, 32'h0, sw_cur);
        step(0, 1, 0, 4'h0, RAM_B + 32'h1000, 32'h0, sw_cur);
        step(0, 0, 1, 4'hF, MMIO_B + 32'h0C, 32'h1, sw_cur);
        step(0, 0, 1, 4'hF, MMIO_B + 32'h00, 32'h1, sw_cur);

        // IDs
        step(0, 1, 0, 4'h0, MMIO_B + 32'h00, 32'h0, sw_cur);
        step(0, 1, 0, 4'h0, MMIO_B + 32'h04, 32'h0, sw_cur);
        step(0, 1, 0, 4'h0, MMIO_B + 32'h08, 32'h0, sw_cur);

        // Switch synchroniser latency
        sw_cur = 16'hA5A5;
        step(0, 0, 0, 4'h0, 32'h0, 32'h0, sw_cur);
        step(0, 1, 0, 4'h0, MMIO_B + 32'h10, 32'h0, sw_cur);
        step(0, 1, 0, 4'h0, MMIO_B + 32'h10, 32'h0, sw_cur);
        step(0, 1, 0, 4'h0, MMIO_B + 32'h10, 32'h0, sw_cur);

        // LED byte write, then same-cycle read/write returns the old value
        step(0, 0, 1, 4'b0001, MMIO_B + 32'h14, 32'hFFFF_1234, sw_cur);
        step(0, 1, 1, 4'b0010, MMIO_B + 32'h14, 32'h0000_AB00, sw_cur);
        step(0, 1, 0, 4'h0, MMIO_B + 32'h14, 32'h0, sw_cur);

        // Counter low word then coherent high word
        step(0, 1, 0, 4'h0, MMIO_B + 32'h18, 32'h0, sw_cur);
        idle(3, sw_cur);
        step(0, 1, 0, 4'h0, MMIO_B + 32'h1C, 32'h0, sw_cur);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) sw_cur = 16'($urandom);
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, 4'($urandom), rand_addr(), $urandom, sw_cur);
        end

        // Reset during LED write + read; RAM survives the reset
        step(0, 0, 1, 4'hF, MMIO_B + 32'h14, 32'h0000_BEEF, sw_cur);
        step(0, 0, 1, 4'hF, RAM_B + 32'h40, 32'h0BAD_F00D, sw_cur);
        step(1, 1, 1, 4'hF, MMIO_B + 32'h14, 32'h0000_1111, sw_cur);
        step(1, 0, 0, 4'h0, 32'h0, 32'h0, sw_cur);
        step(0, 1, 0, 4'h0, RAM_B + 32'h40, 32'h0, sw_cur);
        step(0, 1, 0, 4'h0, MMIO_B + 32'h14, 32'h0, sw_cur);
        step(0, 1, 0, 4'h0, MMIO_B + 32'h18, 32'h0, sw_cur);
        step(0, 1, 0, 4'h0, MMIO_B + 32'h1C, 32'h0, sw_cur);

        idle(3, sw_cur);
        @(negedge clk);
        total++;
        if (rd_q.size() != 0 || cyc_q.size() != 0) begin
            bad++;
            $display("FAIL drain: rd_q=%0d cyc_q=%0d left, want 0", rd_q.size(), cyc_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
- Parametrised successor to the core's data-memory block: byte-lane data RAM plus a memory-mapped I/O page, on the CPU load/store port.
- Reads are synchronous (BRAM-inferable), with a `read_valid` strobe.
- Adds a synchronised switch input, byte-writable LED register, 64-bit cycle counter with coherent hi/lo read, and an access-error flag.

Parameters:
- MEM_BYTES, 4096, RAM size in bytes; power of two, ≥ 8.
- RAM_BASE, 32'h2000_0000, RAM window base; aligned to MEM_BYTES.
- MMIO_BASE, 32'h0010_0000, MMIO page base; 256-byte page, 256-byte aligned.
- SW_WIDTH, 16, switch input width; 1..32.
- LED_WIDTH, 16, LED register width; 1..32.
- ID0, 32'h1719_2051, constant at MMIO+0x00.
- ID1, 32'h1672_6992, constant at MMIO+0x04.
- ID2, 32'h1672_6992, constant at MMIO+0x08.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- read_enable  in  1  load request, sampled at posedge.
- write_enable  in  1  store request, sampled at posedge.
- byte_sel  in  4  write byte enables; bit i selects write_data[8i+7:8i].
- memory_addr  in  32  byte address; bits [1:0] ignored (word access).
- write_data  in  32  store data.
- user_switch  in  SW_WIDTH  asynchronous switch inputs.
- read_data  out  32  load result, registered.
- read_valid  out  1  high for one cycle when read_data holds a new result.
- leds  out  LED_WIDTH  LED register contents.
- access_err  out  1  one-cycle pulse on any access to an unmapped address.

Behaviour:
- **Decode:**
  - RAM hit: memory_addr[31:log2(MEM_BYTES)] == RAM_BASE[31:log2(MEM_BYTES)].
  - MMIO hit: memory_addr[31:8] == MMIO_BASE[31:8].
  - Otherwise unmapped.
  - RAM index = memory_addr[log2(MEM_BYTES)-1:2].
- **RAM:** four 8-bit lanes, MEM_BYTES/4 entries each. Lane i stores write_data[8i+7:8i] when write_enable and byte_sel[i].
- **Read latency:** exactly 1 cycle.
  - read_enable at edge N gives read_data/read_valid valid after edge N, held until the next read.
  - read_data holds its last value when read_valid is low.
- **Read and write in the same cycle, same address:** read returns the pre-write data (read-first). The new data is visible on the following read.
- **MMIO map** (offset, access):
  - 0x00 / 0x04 / 0x08 R: ID0 / ID1 / ID2.
  - 0x10 R: switches, zero-extended. Passed through a 2-flop synchroniser, so a change appears after 2 clocks.
  - 0x14 R/W: LEDs, zero-extended on read. Writes honour byte_sel per lane and truncate to LED_WIDTH.
  - 0x18 R: cycle counter [31:0]. The same read latches counter [63:32] into a shadow register.
  - 0x1C R: shadow [63:32]. Coherent with the preceding 0x18 read.
  - Other offsets in the page: read 0, writes ignored, access_err pulses.
- **Writes to read-only MMIO:** ignored, no error.
- **Cycle counter:** 64-bit, +1 every clock when not in reset; wraps from 2^64-1 to 0.
- **access_err:** registered. Pulses 1 cycle after the edge on which an unmapped read or write was sampled. An unmapped read also returns 0 with read_valid=1.
- **Reset:**
  - Cleared to 0: read_data, read_valid, leds, access_err, counter, shadow, switch synchroniser.
  - RAM contents are not cleared.
  - Requests sampled while reset is high are discarded: no write, no read_valid.
- **Simultaneous read and write to the LED register:** the read returns the old value.

Test Plan:
- Write 32'hDEAD_BEEF to RAM_BASE+0x10 with byte_sel=4'hF; next cycle read -> read_data=32'hDEAD_BEEF, read_valid=1 exactly one cycle after read_enable.
- Then write 32'h0000_0055 with byte_sel=4'b0001 to the same address; read -> 32'hDEAD_BE55. Write 32'h1122_3344 with byte_sel=4'b1000; read -> 32'h11AD_BE55.
- Same-cycle read and write of 32'hCAFE_0000 to RAM_BASE+0x20, old value 32'h0 -> read_data=0; the following read -> 32'hCAFE_0000. Address RAM_BASE+MEM_BYTES-4 is accessible; RAM_BASE+MEM_BYTES -> access_err=1, read_data=0.
- Set user_switch=16'hA5A5 -> an MMIO+0x10 read issued 1 cycle later returns the old value; issued ≥2 cycles later returns 32'h0000_A5A5. Write 32'hFFFF_1234 with byte_sel=4'b0001 to MMIO+0x14 -> leds=16'h0034.
- After reset, at cycle count C, read MMIO+0x18 then MMIO+0x1C -> low word = C, high word = 0. Force the counter to 32'hFFFF_FFFF in the low word, then read 0x18 -> the high word read later is still the latched value, even though the counter carried in between.
- Assert reset while read_enable=1 and write_enable=1 to LEDs -> read_valid=0, leds=0. RAM data written before reset is still readable after reset deasserts.
